// File: rtl/tick_period_meter.sv
`timescale 1ns/1ps
// tick_period_meter
// Measures the number of clock cycles between rising edges of a tick strobe
// that shares clk_i. Reports the last period, a one-cycle valid strobe, a lock
// flag for consecutive periods that agree within TOL, and a timeout flag when
// edges stop arriving.
module tick_period_meter #(
  parameter int CNT_W       = 24,
  parameter int TIMEOUT_CYC = 16_000_000,
  parameter int TOL         = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             locked_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic             tick_q;
  logic             edge_det;
  logic             cnt_at_limit;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] prev_reg, prev_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] diff;
  logic             have_prev_reg, have_prev_next;
  logic             valid_reg, valid_next;
  logic             locked_reg, locked_next;
  logic             timeout_reg, timeout_next;

  // Rising edge of the tick; a long high level produces a single edge.
  assign edge_det     = tick_i & ~tick_q;
  assign cnt_at_limit = (cnt_reg >= TIMEOUT_C);

  // Unsigned absolute difference of the current and previous period; the
  // ordered subtraction cannot wrap.
  assign diff = (cnt_reg >= prev_reg) ? (cnt_reg - prev_reg) : (prev_reg - cnt_reg);

  // State and datapath registers; the edge detector keeps tracking during clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= WAIT_FIRST;
      tick_q        <= 1'b0;
      cnt_reg       <= '0;
      prev_reg      <= '0;
      period_reg    <= '0;
      have_prev_reg <= 1'b0;
      valid_reg     <= 1'b0;
      locked_reg    <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tick_q        <= tick_i;
      cnt_reg       <= cnt_next;
      prev_reg      <= prev_next;
      period_reg    <= period_next;
      have_prev_reg <= have_prev_next;
      valid_reg     <= valid_next;
      locked_reg    <= locked_next;
      timeout_reg   <= timeout_next;
    end
  end

  // Next state: clear wins, then an edge, then the timeout limit.
  always_comb begin
    state_next = state_reg;
    if (clear_i) begin
      state_next = WAIT_FIRST;
    end else begin
      case (state_reg)
        WAIT_FIRST: if (edge_det) state_next = MEASURE;
        MEASURE:    if (!edge_det && cnt_at_limit) state_next = WAIT_FIRST;
        default:    state_next = WAIT_FIRST;
      endcase
    end
  end

  // Counter, period capture, lock and timeout updates for each state.
  always_comb begin
    cnt_next       = cnt_reg;
    prev_next      = prev_reg;
    period_next    = period_reg;
    have_prev_next = have_prev_reg;
    valid_next     = 1'b0;
    locked_next    = locked_reg;
    timeout_next   = timeout_reg;

    if (clear_i) begin
      cnt_next       = '0;
      prev_next      = '0;
      period_next    = '0;
      have_prev_next = 1'b0;
      locked_next    = 1'b0;
      timeout_next   = 1'b0;
    end else begin
      case (state_reg)
        WAIT_FIRST: begin
          // The first edge only starts the count; it releases a pending timeout.
          if (edge_det) begin
            cnt_next     = ONE_C;
            timeout_next = 1'b0;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            period_next    = cnt_reg;
            valid_next     = 1'b1;
            cnt_next       = ONE_C;
            prev_next      = cnt_reg;
            have_prev_next = 1'b1;
            if (have_prev_reg) begin
              locked_next = (diff <= TOL_C);
            end
          end else if (!cnt_at_limit) begin
            cnt_next = cnt_reg + ONE_C;
          end else begin
            // Ticks have stopped: drop lock and history, keep the last period.
            timeout_next   = 1'b1;
            locked_next    = 1'b0;
            have_prev_next = 1'b0;
            cnt_next       = '0;
          end
        end
        default: begin
          cnt_next = '0;
        end
      endcase
    end
  end

  assign period_o  = period_reg;
  assign valid_o   = valid_reg;
  assign locked_o  = locked_reg;
  assign timeout_o = timeout_reg;

endmodule

// File: tb/tb_tick_period_meter.sv
`timescale 1ns/1ps
// Directed bench for tick_period_meter with CNT_W=8, TIMEOUT_CYC=100, TOL=2.
module tb_tick_period_meter;

  localparam int CNT_W       = 8;
  localparam int TIMEOUT_CYC = 100;
  localparam int TOL         = 2;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             tick    = 1'b0;
  logic             clear   = 1'b0;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             locked;
  logic             timeout;

  int total     = 0;
  int bad       = 0;
  int valid_cnt = 0;

  tick_period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TOL        (TOL)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .tick_i   (tick),
    .clear_i  (clear),
    .period_o (period),
    .valid_o  (valid),
    .locked_o (locked),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  // One clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (valid) valid_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    $display("edge: period=%0d valid=%0b locked=%0b timeout=%0b",
             period, valid, locked, timeout);
  endtask

  // Rising edge exactly p cycles after the previous one.
  task automatic gap_pulse(input int p);
    idle(p - 1);
    pulse();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // 1. Reset with the tick toggling, then a single pulse.
    repeat (4) begin
      tick = ~tick;
      @(posedge clk);
      #1;
    end
    chk("rst_period", 32'(period), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_timeout", 32'(timeout), 0);
    tick = 1'b0;
    step();
    rst_n = 1'b1;
    idle(2);
    pulse();
    chk("first_pulse_valid", 32'(valid), 0);
    chk("first_pulse_period", 32'(period), 0);

    // 2. Steady 10-cycle rate.
    gap_pulse(10);
    chk("steady1_valid", 32'(valid), 1);
    chk("steady1_period", 32'(period), 10);
    chk("steady1_locked", 32'(locked), 0);
    chk("steady1_vcnt", 32'(valid_cnt), 1);
    gap_pulse(10);
    chk("steady2_period", 32'(period), 10);
    chk("steady2_locked", 32'(locked), 1);
    chk("steady2_vcnt", 32'(valid_cnt), 2);

    // 3. Rate change to 20.
    gap_pulse(20);
    chk("rate20a_period", 32'(period), 20);
    chk("rate20a_locked", 32'(locked), 0);
    gap_pulse(20);
    chk("rate20b_period", 32'(period), 20);
    chk("rate20b_locked", 32'(locked), 1);

    // 4. Jitter within and beyond tolerance, then a wide tick level.
    gap_pulse(10);
    chk("jit10a_locked", 32'(locked), 0);
    gap_pulse(10);
    chk("jit10b_locked", 32'(locked), 1);
    gap_pulse(11);
    chk("jit11_period", 32'(period), 11);
    chk("jit11_locked", 32'(locked), 1);
    gap_pulse(9);
    chk("jit9_period", 32'(period), 9);
    chk("jit9_locked", 32'(locked), 1);
    gap_pulse(10);
    chk("jit10c_locked", 32'(locked), 1);
    gap_pulse(13);
    chk("jit13_period", 32'(period), 13);
    chk("jit13_locked", 32'(locked), 0);
    idle(12);
    tick = 1'b1;
    step();
    chk("wide_valid", 32'(valid), 1);
    chk("wide_period", 32'(period), 13);
    chk("wide_locked", 32'(locked), 1);
    idle(4);
    tick = 1'b0;
    chk("wide_vcnt", 32'(valid_cnt), 11);
    idle(8);
    pulse();
    chk("after_wide_period", 32'(period), 13);
    chk("after_wide_vcnt", 32'(valid_cnt), 12);

    // 5. Timeout boundary.
    idle(99);
    chk("pre_timeout", 32'(timeout), 0);
    chk("pre_timeout_locked", 32'(locked), 1);
    step();
    chk("timeout_set", 32'(timeout), 1);
    chk("timeout_locked", 32'(locked), 0);
    chk("timeout_period", 32'(period), 13);
    idle(5);
    chk("timeout_held", 32'(timeout), 1);
    pulse();
    chk("timeout_clr", 32'(timeout), 0);
    chk("timeout_clr_valid", 32'(valid), 0);
    chk("timeout_clr_vcnt", 32'(valid_cnt), 12);
    idle(99);
    chk("edge100_pre_timeout", 32'(timeout), 0);
    pulse();
    chk("edge100_period", 32'(period), 100);
    chk("edge100_valid", 32'(valid), 1);
    chk("edge100_timeout", 32'(timeout), 0);
    chk("edge100_locked", 32'(locked), 0);
    gap_pulse(100);
    chk("edge100b_locked", 32'(locked), 1);
    chk("edge100b_vcnt", 32'(valid_cnt), 14);

    // 6. Clear coinciding with an edge; the held tick must not count later.
    idle(3);
    tick  = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_valid", 32'(valid), 0);
    chk("clear_period", 32'(period), 0);
    chk("clear_locked", 32'(locked), 0);
    chk("clear_timeout", 32'(timeout), 0);
    step();
    tick = 1'b0;
    chk("clear_vcnt", 32'(valid_cnt), 14);
    idle(4);
    pulse();
    chk("restart_first_valid", 32'(valid), 0);
    gap_pulse(10);
    chk("restart_valid", 32'(valid), 1);
    chk("restart_period", 32'(period), 10);
    chk("restart_locked", 32'(locked), 0);
    chk("restart_vcnt", 32'(valid_cnt), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
